// File: rtl/sha_512_ctrl_pkg.sv
// +-----------------------------------------------------------------------------
// | sha_const : shared state, variant and truncation definitions for the
// |             SHA-512 family message controller.
// | Revision  : 1.0
// +-----------------------------------------------------------------------------
`default_nettype none

package sha_const;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_PAD  = 3'd2,
    S_FIRE = 3'd3,
    S_WAIT = 3'd4,
    S_DONE = 3'd5
  } state_t;

  localparam logic [1:0] OP_512_224 = 2'd0;
  localparam logic [1:0] OP_512_256 = 2'd1;
  localparam logic [1:0] OP_384     = 2'd2;
  localparam logic [1:0] OP_512     = 2'd3;

  localparam int unsigned DW_512_224 = 224;
  localparam int unsigned DW_512_256 = 256;
  localparam int unsigned DW_384     = 384;
  localparam int unsigned DW_512     = 512;

  localparam logic [63:0] PAD_MARK = 64'h8000_0000_0000_0000;

  // Keep the leading digest bits of the selected variant, zero the rest.
  function automatic logic [511:0] truncate(input logic [1:0] op, input logic [511:0] h);
    logic [511:0] m;
    case (op)
      OP_512_224: m = {{DW_512_224{1'b1}}, {(DW_512 - DW_512_224){1'b0}}};
      OP_512_256: m = {{DW_512_256{1'b1}}, {(DW_512 - DW_512_256){1'b0}}};
      OP_384:     m = {{DW_384{1'b1}},     {(DW_512 - DW_384){1'b0}}};
      default:    m = {DW_512{1'b1}};
    endcase
    return h & m;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sha_512_ctrl_pad.sv
// +-----------------------------------------------------------------------------
// | sha_pad : combinational last-word byte masking, 0x80 marker insertion and
// |           block zero-fill with the 128-bit length words.
// | Revision: 1.0
// +-----------------------------------------------------------------------------
`default_nettype none

module sha_pad
  import sha_const::*;
(
  input  logic [63:0]   msg_data,
  input  logic [3:0]    msg_bytes,
  output logic [63:0]   last_word,
  output logic          mark_next,
  input  logic [1023:0] blk_in,
  input  logic [4:0]    wp,
  input  logic          mark,
  input  logic [127:0]  len,
  output logic [1023:0] blk_out,
  output logic          fits
);

  logic [6:0] shamt;
  logic [5:0] wpe;

  always_comb begin
    shamt     = {msg_bytes, 3'b000};
    // A full 8-byte word shifts the marker out; it then lands in the next word.
    last_word = (msg_data & ~({64{1'b1}} >> shamt)) | (PAD_MARK >> shamt);
    mark_next = (msg_bytes >= 4'd8);

    wpe  = {1'b0, wp} + {5'd0, mark};
    fits = (wpe <= 6'd14);

    blk_out = blk_in;
    for (int i = 0; i < 16; i++) begin
      if (5'(i) >= wp)
        blk_out[i*64 +: 64] = (mark && (5'(i) == wp)) ? PAD_MARK : 64'd0;
    end
    if (fits) begin
      blk_out[14*64 +: 64] = len[127:64];
      blk_out[15*64 +: 64] = len[63:0];
    end
  end

endmodule

`default_nettype wire

// File: rtl/sha_512_ctrl.sv
// +-----------------------------------------------------------------------------
// | sha_512_ctrl : message buffering, padding and block sequencing for an
// |                external SHA-512 family compression core.
// | Optional abort input enabled by macro SHA_512_CTRL_ABORT_EN.
// | Revision     : 1.0
// +-----------------------------------------------------------------------------
`default_nettype none

module sha_512_ctrl
  import sha_const::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [1:0]    op,
  input  logic          msg_valid,
  output logic          msg_ready,
  input  logic [63:0]   msg_data,
  input  logic          msg_last,
  input  logic [3:0]    msg_bytes,
  output logic [1023:0] core_data,
  output logic [127:0]  core_index,
  output logic [1:0]    core_op,
  output logic          core_enable,
  input  logic [511:0]  core_hash,
  input  logic          core_ready,
  output logic [511:0]  digest,
  output logic          digest_valid,
  input  logic          digest_ack,
  output logic          busy
`ifdef SHA_512_CTRL_ABORT_EN
  ,
  input  logic          abort
`endif
);

  state_t         state, state_nx;
  logic [1023:0]  blk_q;
  logic [4:0]     wp;
  logic [127:0]   len;
  logic [127:0]   blk;
  logic [1:0]     op_q;
  logic           final_q;
  logic           pend_q;
  logic           mark_q;
  logic [511:0]   digest_q;
  logic           kill;

  logic [63:0]    last_word;
  logic           mark_next;
  logic [1023:0]  pad_blk;
  logic           fits;

`ifdef SHA_512_CTRL_ABORT_EN
  assign kill = abort && (state != S_IDLE);
`else
  assign kill = 1'b0;
`endif

  sha_pad u_pad (
    .msg_data  (msg_data),
    .msg_bytes (msg_bytes),
    .last_word (last_word),
    .mark_next (mark_next),
    .blk_in    (blk_q),
    .wp        (wp),
    .mark      (mark_q),
    .len       (len),
    .blk_out   (pad_blk),
    .fits      (fits)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx     = state;
    msg_ready    = 1'b0;
    core_enable  = 1'b0;
    digest_valid = 1'b0;
    case (state)
      S_IDLE: if (start) state_nx = S_LOAD;
      S_LOAD: begin
        msg_ready = 1'b1;
        if (msg_valid) begin
          if (msg_last)          state_nx = S_PAD;
          else if (wp == 5'd15)  state_nx = S_FIRE;
        end
      end
      S_PAD:  state_nx = S_FIRE;
      S_FIRE: begin
        core_enable = 1'b1;
        state_nx    = S_WAIT;
      end
      S_WAIT: if (core_ready) state_nx = final_q ? S_DONE : (pend_q ? S_PAD : S_LOAD);
      S_DONE: begin
        digest_valid = 1'b1;
        if (digest_ack) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
    if (kill) begin
      state_nx     = S_IDLE;
      msg_ready    = 1'b0;
      core_enable  = 1'b0;
      digest_valid = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      blk_q    <= '0;
      wp       <= '0;
      len      <= '0;
      blk      <= '0;
      op_q     <= '0;
      final_q  <= 1'b0;
      pend_q   <= 1'b0;
      mark_q   <= 1'b0;
      digest_q <= '0;
    end else if (!kill) begin
      case (state)
        S_IDLE: if (start) begin
          wp      <= '0;
          len     <= '0;
          blk     <= '0;
          op_q    <= op;
          final_q <= 1'b0;
          pend_q  <= 1'b0;
          mark_q  <= 1'b0;
        end
        S_LOAD: if (msg_valid) begin
          if (msg_last) begin
            blk_q[{wp[3:0], 6'd0} +: 64] <= last_word;
            len    <= len + {121'd0, msg_bytes, 3'b000};
            mark_q <= mark_next;
          end else begin
            blk_q[{wp[3:0], 6'd0} +: 64] <= msg_data;
            len <= len + 128'd64;
          end
          wp <= wp + 5'd1;
        end
        S_PAD: begin
          blk_q   <= pad_blk;
          final_q <= fits;
          pend_q  <= !fits;
          // With the buffer already full the marker moves on to the next block.
          if (wp != 5'd16) mark_q <= 1'b0;
        end
        S_FIRE: blk <= blk + 128'd1;
        S_WAIT: if (core_ready) begin
          if (final_q) digest_q <= truncate(op_q, core_hash);
          else         wp <= '0;
        end
        default: ;
      endcase
    end
  end

  assign core_data  = blk_q;
  assign core_index = (state == S_FIRE) ? blk + 128'd1 : blk;
  assign core_op    = op_q;
  assign digest     = digest_q;
  assign busy       = (state != S_IDLE);

endmodule

`default_nettype wire

// File: doc/sha_512_ctrl.md
SHA_512_CTRL -- requirements
Module: sha_512_ctrl

Interface
REQ-001 clk  in  1  single clock; all state updates on its rising edge.
REQ-002 rst  in  1  synchronous, active-high reset.
REQ-003 start  in  1  begins a new message when sampled high in IDLE; ignored elsewhere.
REQ-004 op  in  2  variant, latched at start: 0=SHA-512/224, 1=SHA-512/256, 2=SHA-384, 3=SHA-512.
REQ-005 msg_valid/msg_ready  in/out  1/1  word handshake; a transfer occurs when both are high.
REQ-006 msg_data  in  64  message word, big-endian: first byte in [63:56].
REQ-007 msg_last  in  1  marks the final word of the message.
REQ-008 msg_bytes  in  4  valid bytes in the last word, 1..8, left-aligned; ignored when msg_last=0.
REQ-009 core_data  out  1024  block to the core; word i at bits [i*64 +: 64].
REQ-010 core_index / core_op / core_enable  out  128/2/1  block number (first block=1), variant, 1-cycle start pulse.
REQ-011 core_hash / core_ready  in  512/1  core result {a..h}, a at [511:448]; valid only while core_ready=1.
REQ-012 digest / digest_valid / digest_ack  out/out/in  512/1/1  truncated result, left-aligned, zero-filled.
REQ-013 busy  out  1  high in every state except IDLE.

Function
REQ-014 States SHALL be IDLE, LOAD, PAD, FIRE, WAIT and DONE.
REQ-015 IDLE: on start, SHALL clear word pointer wp, bit-length counter len (128 bit) and block counter blk to 0, latch op, and go to LOAD.
REQ-016 LOAD: SHALL hold msg_ready=1 and store each transferred word at buf[wp]; wp+1; len+64 (non-last) or len+8*msg_bytes (last).
REQ-017 Last word: SHALL be byte-masked, with 0x80 placed in the byte after the last valid byte (msg_bytes=8: 0x80 goes into [63:56] of the next word); SHALL go to PAD.
REQ-018 LOAD with wp reaching 16 and no last: SHALL go to FIRE with msg_ready=0.
REQ-019 PAD: SHALL zero-fill the remaining words; when wp<=14 after the 0x80 byte, SHALL write len[127:64] to word 14 and len[63:0] to word 15 and mark the block final; otherwise SHALL send this block non-final and build a further zero block with the length words, also final.
REQ-020 FIRE: SHALL assert core_enable for exactly one cycle, with core_index=blk+1 and core_op=op; blk+1; then go to WAIT.
REQ-021 WAIT: SHALL wait for core_ready=1; non-final block -> LOAD with wp=0 (or PAD when a length-only block is pending); final block -> capture core_hash and go to DONE.
REQ-022 Truncation: op0 keeps [511:288], op1 [511:256], op2 [511:128], op3 all 512 bits; all other bits SHALL be 0.
REQ-023 DONE: digest_valid=1 and digest SHALL stay stable until digest_ack=1, then go to IDLE; a start in the same cycle SHALL be ignored.
REQ-024 core_data SHALL stay constant from FIRE until core_ready; msg_ready SHALL be 0 outside LOAD.
REQ-025 Latency: FIRE to core_ready SHALL be 161 cycles (80 schedule + 80 round + 1 load).

Reset
REQ-026 On rst=1, SHALL enter IDLE next edge with msg_ready=0, core_enable=0, digest_valid=0, busy=0, digest=0, counters=0; reset in any state, including mid-WAIT, SHALL discard the message.

Configuration
REQ-027 With SHA_512_CTRL_ABORT_EN defined, SHALL add input abort (1 bit): abort=1 in any non-IDLE state SHALL force IDLE next cycle, with no digest_valid, no further core_enable, and any in-flight core_ready ignored.
REQ-028 Without SHA_512_CTRL_ABORT_EN, the abort port and its logic SHALL be absent.

Structure
REQ-029 State encoding, the op encoding and the truncation widths SHALL live in shared package sha_const.
REQ-030 Byte masking, 0x80 insertion and length-word generation SHALL be in sub-module sha_pad (combinational); the core is instantiated outside this block.

Verification
REQ-031 SHA-512 of "abc" (one word, msg_bytes=3): ddaf35a193617aba...a54ca49f; exactly one core_enable.
REQ-032 SHA-384 of "abc": cb00753f45a35e8b...8086072ba1e7cc2358baeca134c825a7; low 128 bits zero.
REQ-033 SHA-512/224 of "abc": 4634270f707b6a54daae7530460842e20e37ed265ceee9a43e8924aa; one block; low bits zero.
REQ-034 111-byte message -> one block; 112-byte message -> two core_enable pulses with core_index 1 then 2; length word = 896.
REQ-035 Random msg_valid gaps and digest_ack delayed 10 cycles -> identical digest; digest stable while waiting for ack.
REQ-036 rst pulse during WAIT, then new "abc" -> correct digest, no stale digest_valid; with SHA_512_CTRL_ABORT_EN, the same holds for abort.
